// File: rtl/calc_mailbox.sv
// ----------------------------------------------------------------------------
// calc_mailbox
//
// Memory-mapped mailbox between the calculator keypad front-end and the
// single-cycle CPU. The front-end loads operands and an opcode, then raises
// fpgaStart to let the CPU execute. The CPU reads the operands through its
// data port and posts a result. A watchdog aborts a run that never posts a
// result within TIMEOUT cycles.
//
// Ports:
//   hz100       in   clock
//   reset       in   asynchronous active-low reset
//   fpgaAddr    in   front-end write address
//   fpgaWData   in   front-end write data
//   fpgaWrEn    in   front-end write enable (a write on every high cycle)
//   fpgaStart   in   front-end run request; its 0->1 transition starts a run
//   fpgaRdAddr  in   front-end read address
//   fpgaRdData  out  front-end read data, one-cycle registered latency
//   cpuAddr     in   CPU data address
//   cpuWData    in   CPU store data
//   cpuWrEn     in   CPU store strobe
//   cpuRdData   out  CPU load data, combinational
//   cpuRun      out  CPU execute enable
//   busy        out  high while a run is in progress
// ----------------------------------------------------------------------------
module calc_mailbox #(
    parameter logic [31:0] A_ADDR    = 32'd220,
    parameter logic [31:0] B_ADDR    = 32'd260,
    parameter logic [31:0] OP_ADDR   = 32'd300,
    parameter logic [31:0] RES_ADDR  = 32'd460,
    parameter logic [31:0] STAT_ADDR = 32'd464,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [31:0] fpgaAddr,
    input  logic [31:0] fpgaWData,
    input  logic        fpgaWrEn,
    input  logic        fpgaStart,
    input  logic [31:0] fpgaRdAddr,
    output logic [31:0] fpgaRdData,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWData,
    input  logic        cpuWrEn,
    output logic [31:0] cpuRdData,
    output logic        cpuRun,
    output logic        busy
);

    // Watchdog width: at least 8 bits, wider if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [31:0]      reg_a_q,   reg_a_d;
    logic [31:0]      reg_b_q,   reg_b_d;
    logic [3:0]       reg_op_q,  reg_op_d;
    logic [31:0]      reg_res_q, reg_res_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]      fpga_rd_q, fpga_rd_d;
    logic             start_q;
    logic             armed_q;

    // ------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------
    logic fe_wr_a, fe_wr_b, fe_wr_op;
    logic start_edge;
    logic res_store;
    logic timeout_hit;
    logic [31:0] status;

    assign fe_wr_a  = fpgaWrEn && (fpgaAddr == A_ADDR);
    assign fe_wr_b  = fpgaWrEn && (fpgaAddr == B_ADDR);
    assign fe_wr_op = fpgaWrEn && (fpgaAddr == OP_ADDR);

    // start_q is cleared by reset, so a request held high across reset
    // release would look like a fresh edge. armed_q only sets once
    // fpgaStart has been seen low, which forces a real 0->1 transition.
    assign start_edge = fpgaStart && !start_q && armed_q;

    assign res_store   = cpuWrEn && (cpuAddr == RES_ADDR);
    assign timeout_hit = (cnt_q == CNT_LAST);

    assign status = {29'b0, state_q == S_ERR, state_q == S_DONE, state_q == S_RUN};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        reg_op_d  = reg_op_q;
        reg_res_d = reg_res_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (fe_wr_a)  reg_a_d  = fpgaWData;
                if (fe_wr_b)  reg_b_d  = fpgaWData;
                if (fe_wr_op) reg_op_d = fpgaWData[3:0];
                // A write in the same cycle as the start edge still lands,
                // so the CPU sees the new value on its first cycle.
                if (start_edge) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end

            S_RUN: begin
                // Operands are frozen; front-end writes are dropped here.
                cnt_d = cnt_q + CNT_W'(1);
                // The CPU result wins over a timeout in the same cycle.
                if (res_store) begin
                    reg_res_d = cpuWData;
                    state_d   = S_DONE;
                end else if (timeout_hit) begin
                    reg_res_d = 32'hFFFF_FFFF;
                    state_d   = S_ERR;
                end
            end

            S_DONE, S_ERR: begin
                // Writing operand A is the front-end's way of starting the
                // next calculation; the old result stays readable.
                if (fe_wr_a) begin
                    reg_a_d = fpgaWData;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read maps
    // ------------------------------------------------------------------
    always_comb begin
        cpuRdData = 32'b0;
        if      (cpuAddr == A_ADDR)    cpuRdData = reg_a_q;
        else if (cpuAddr == B_ADDR)    cpuRdData = reg_b_q;
        else if (cpuAddr == OP_ADDR)   cpuRdData = {28'b0, reg_op_q};
        else if (cpuAddr == RES_ADDR)  cpuRdData = reg_res_q;
        else if (cpuAddr == STAT_ADDR) cpuRdData = status;
    end

    // The front-end cannot see the status word.
    always_comb begin
        fpga_rd_d = 32'b0;
        if      (fpgaRdAddr == A_ADDR)   fpga_rd_d = reg_a_q;
        else if (fpgaRdAddr == B_ADDR)   fpga_rd_d = reg_b_q;
        else if (fpgaRdAddr == OP_ADDR)  fpga_rd_d = {28'b0, reg_op_q};
        else if (fpgaRdAddr == RES_ADDR) fpga_rd_d = reg_res_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            reg_op_q  <= '0;
            reg_res_q <= '0;
            cnt_q     <= '0;
            fpga_rd_q <= '0;
            start_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            reg_op_q  <= reg_op_d;
            reg_res_q <= reg_res_d;
            cnt_q     <= cnt_d;
            fpga_rd_q <= fpga_rd_d;
            // Edges seen outside IDLE are consumed here, so they cannot
            // fire later when the mailbox returns to IDLE.
            start_q   <= fpgaStart;
            if (!fpgaStart) armed_q <= 1'b1;
        end
    end

    assign fpgaRdData = fpga_rd_q;
    assign cpuRun     = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_calc_mailbox.sv
// ----------------------------------------------------------------------------
// tb_calc_mailbox
//
// Directed bench for calc_mailbox. A behavioural model tracks the mailbox
// in terms of modes and elapsed run cycles; a compare process checks all DUT
// outputs against it on every falling clock edge. Directed steps add literal
// expectations taken from the intended behaviour.
// ----------------------------------------------------------------------------
module tb_calc_mailbox;

    localparam logic [31:0] A_ADDR    = 32'd220;
    localparam logic [31:0] B_ADDR    = 32'd260;
    localparam logic [31:0] OP_ADDR   = 32'd300;
    localparam logic [31:0] RES_ADDR  = 32'd460;
    localparam logic [31:0] STAT_ADDR = 32'd464;
    localparam int          TIMEOUT   = 200;

    logic        hz100      = 1'b0;
    logic        reset      = 1'b0;
    logic [31:0] fpgaAddr   = '0;
    logic [31:0] fpgaWData  = '0;
    logic        fpgaWrEn   = 1'b0;
    logic        fpgaStart  = 1'b0;
    logic [31:0] fpgaRdAddr = '0;
    logic [31:0] fpgaRdData;
    logic [31:0] cpuAddr    = '0;
    logic [31:0] cpuWData   = '0;
    logic        cpuWrEn    = 1'b0;
    logic [31:0] cpuRdData;
    logic        cpuRun;
    logic        busy;

    always #10 hz100 = ~hz100;

    calc_mailbox dut (
        .hz100      (hz100),
        .reset      (reset),
        .fpgaAddr   (fpgaAddr),
        .fpgaWData  (fpgaWData),
        .fpgaWrEn   (fpgaWrEn),
        .fpgaStart  (fpgaStart),
        .fpgaRdAddr (fpgaRdAddr),
        .fpgaRdData (fpgaRdData),
        .cpuAddr    (cpuAddr),
        .cpuWData   (cpuWData),
        .cpuWrEn    (cpuWrEn),
        .cpuRdData  (cpuRdData),
        .cpuRun     (cpuRun),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_RUN, M_DONE, M_ERR} mode_t;

    mode_t       m_mode       = M_IDLE;
    logic [31:0] m_a          = '0;
    logic [31:0] m_b          = '0;
    logic [31:0] m_op         = '0;
    logic [31:0] m_res        = '0;
    logic [31:0] m_rd         = '0;
    int          m_run_cycles = 0;
    bit          m_prev_start = 1'b0;
    bit          m_seen_low   = 1'b0;

    function automatic logic [31:0] model_read(input logic [31:0] addr, input bit cpu_side);
        logic [31:0] stat;
        stat = {29'b0, m_mode == M_ERR, m_mode == M_DONE, m_mode == M_RUN};
        if (addr == A_ADDR)              return m_a;
        if (addr == B_ADDR)              return m_b;
        if (addr == OP_ADDR)             return m_op;
        if (addr == RES_ADDR)            return m_res;
        if (cpu_side && addr == STAT_ADDR) return stat;
        return 32'b0;
    endfunction

    always @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            m_mode = M_IDLE;
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_rd = '0;
            m_run_cycles = 0;
            m_prev_start = 1'b0;
            m_seen_low   = 1'b0;
        end else begin
            m_rd = model_read(fpgaRdAddr, 1'b0);
            case (m_mode)
                M_IDLE: begin
                    if (fpgaWrEn && fpgaAddr == A_ADDR)  m_a  = fpgaWData;
                    if (fpgaWrEn && fpgaAddr == B_ADDR)  m_b  = fpgaWData;
                    if (fpgaWrEn && fpgaAddr == OP_ADDR) m_op = {28'b0, fpgaWData[3:0]};
                    if (fpgaStart && !m_prev_start && m_seen_low) begin
                        m_mode = M_RUN;
                        m_run_cycles = 0;
                    end
                end
                M_RUN: begin
                    m_run_cycles++;
                    if (cpuWrEn && cpuAddr == RES_ADDR) begin
                        m_res  = cpuWData;
                        m_mode = M_DONE;
                    end else if (m_run_cycles == TIMEOUT) begin
                        m_res  = 32'hFFFF_FFFF;
                        m_mode = M_ERR;
                    end
                end
                default: begin
                    if (fpgaWrEn && fpgaAddr == A_ADDR) begin
                        m_a    = fpgaWData;
                        m_mode = M_IDLE;
                    end
                end
            endcase
            m_prev_start = fpgaStart;
            if (!fpgaStart) m_seen_low = 1'b1;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge hz100) begin
        check("cpuRun",     {31'b0, cpuRun}, {31'b0, m_mode == M_RUN});
        check("busy",       {31'b0, busy},   {31'b0, m_mode == M_RUN});
        check("fpgaRdData", fpgaRdData,      m_rd);
        check("cpuRdData",  cpuRdData,       model_read(cpuAddr, 1'b1));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Leaves the bench just after a falling edge, in the middle of the low
    // phase, where inputs can change safely before the next rising edge.
    task automatic tick();
        @(negedge hz100);
        #1;
    endtask

    task automatic fe_write(input logic [31:0] addr, input logic [31:0] data);
        fpgaAddr  = addr;
        fpgaWData = data;
        fpgaWrEn  = 1'b1;
        tick();
        fpgaWrEn  = 1'b0;
    endtask

    task automatic cpu_read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        cpuAddr = addr;
        #1;
        check(name, cpuRdData, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state
        repeat (3) tick();
        check("rst_cpuRun", {31'b0, cpuRun}, 32'd0);
        check("rst_fpgaRdData", fpgaRdData, 32'd0);
        cpu_read_chk("rst_regA", A_ADDR, 32'd0);
        cpu_read_chk("rst_status", STAT_ADDR, 32'd0);
        reset = 1'b1;
        tick();

        // Load operands, then launch
        fe_write(A_ADDR, 32'd12);
        fe_write(OP_ADDR, 32'hFFFF_FFF8);
        fe_write(B_ADDR, 32'd34);
        fe_write(32'd999, 32'd55);
        fpgaStart = 1'b1;
        tick();
        check("load_cpuRun", {31'b0, cpuRun}, 32'd1);
        check("load_busy", {31'b0, busy}, 32'd1);
        cpu_read_chk("load_A", A_ADDR, 32'd12);
        cpu_read_chk("load_OP", OP_ADDR, 32'd8);
        cpu_read_chk("load_B", B_ADDR, 32'd34);
        cpu_read_chk("load_status", STAT_ADDR, 32'd1);
        tick();
        fpgaStart = 1'b0;

        // Freeze: front-end writes ignored during RUN
        fe_write(A_ADDR, 32'd7);
        cpu_read_chk("freeze_A", A_ADDR, 32'd12);
        cpu_read_chk("unmapped_cpu", 32'd1000, 32'd0);

        // Result
        cpuAddr = RES_ADDR; cpuWData = 32'd46; cpuWrEn = 1'b1;
        tick();
        cpuWrEn = 1'b0;
        check("done_cpuRun", {31'b0, cpuRun}, 32'd0);
        cpu_read_chk("done_status", STAT_ADDR, 32'd2);
        fpgaRdAddr = RES_ADDR;
        tick();
        check("done_fpgaRd", fpgaRdData, 32'd46);

        // Ignored in DONE: CPU stores, start edges, B writes
        cpuAddr = RES_ADDR; cpuWData = 32'd5; cpuWrEn = 1'b1;
        tick();
        cpuWrEn = 1'b0;
        cpu_read_chk("done_cpu_store_ignored", RES_ADDR, 32'd46);
        fpgaStart = 1'b1;
        tick();
        fpgaStart = 1'b0;
        tick();
        cpu_read_chk("done_start_ignored", STAT_ADDR, 32'd2);
        fe_write(B_ADDR, 32'd99);
        cpu_read_chk("done_B_ignored", B_ADDR, 32'd34);

        // Return to IDLE via an A write
        fe_write(A_ADDR, 32'd7);
        cpu_read_chk("ret_A", A_ADDR, 32'd7);
        cpu_read_chk("ret_status", STAT_ADDR, 32'd0);
        cpu_read_chk("ret_res", RES_ADDR, 32'd46);

        // Timeout: count RUN cycles with no result
        fpgaStart = 1'b1;
        tick();
        fpgaStart = 1'b0;
        n = 0;
        while (cpuRun && n < 400) begin
            n++;
            tick();
        end
        check("timeout_run_cycles", n, 32'd200);
        cpu_read_chk("timeout_status", STAT_ADDR, 32'd4);
        cpu_read_chk("timeout_res", RES_ADDR, 32'hFFFF_FFFF);
        fe_write(A_ADDR, 32'd1);

        // Collision: result store on the final watchdog cycle
        fpgaStart = 1'b1;
        tick();
        fpgaStart = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("coll_still_running", {31'b0, cpuRun}, 32'd1);
        cpuAddr = RES_ADDR; cpuWData = 32'd99; cpuWrEn = 1'b1;
        tick();
        cpuWrEn = 1'b0;
        cpu_read_chk("coll_status", STAT_ADDR, 32'd2);
        cpu_read_chk("coll_res", RES_ADDR, 32'd99);
        fe_write(A_ADDR, 32'd2);

        // Simultaneous write and start edge in IDLE
        fpgaAddr = B_ADDR; fpgaWData = 32'd5; fpgaWrEn = 1'b1; fpgaStart = 1'b1;
        tick();
        fpgaWrEn = 1'b0;
        check("simul_cpuRun", {31'b0, cpuRun}, 32'd1);
        cpu_read_chk("simul_B", B_ADDR, 32'd5);

        // Reset mid-RUN with fpgaStart held high throughout
        repeat (50) tick();
        reset = 1'b0;
        #1;
        check("midrst_cpuRun", {31'b0, cpuRun}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_fpgaRd", fpgaRdData, 32'd0);
        cpu_read_chk("midrst_B", B_ADDR, 32'd0);
        cpu_read_chk("midrst_res", RES_ADDR, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("held_start_no_run", {31'b0, cpuRun}, 32'd0);
        fpgaStart = 1'b0;
        tick();
        fpgaStart = 1'b1;
        tick();
        check("restart_cpuRun", {31'b0, cpuRun}, 32'd1);
        fpgaStart = 1'b0;

        // Store to a non-result address is ignored; then a real result
        cpuAddr = STAT_ADDR; cpuWData = 32'd3; cpuWrEn = 1'b1;
        tick();
        check("wrong_addr_still_run", {31'b0, cpuRun}, 32'd1);
        cpuAddr = RES_ADDR; cpuWData = 32'd77;
        tick();
        cpuWrEn = 1'b0;
        cpu_read_chk("final_status", STAT_ADDR, 32'd2);
        cpu_read_chk("final_res", RES_ADDR, 32'd77);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_mailbox.md
# calc_mailbox

Memory-mapped mailbox between the calculator keypad front-end and the single-cycle CPU. It responds to the front-end's operand/opcode writes and its result-read port. It gates CPU execution on the front-end's start request and holds the CPU-produced result for display. A watchdog counter aborts a run that never posts a result.

## Interface
Parameters:
- A_ADDR, 220, address of operand A register
- B_ADDR, 260, address of operand B register
- OP_ADDR, 300, address of opcode register (one-hot: 8 add, 4 sub, 2 mul, 1 div)
- RES_ADDR, 460, address of result register
- STAT_ADDR, 464, address of status register (CPU read-only)
- TIMEOUT, 200, maximum RUN cycles before abort

Ports:
- hz100  in  1  clock
- reset  in  1  asynchronous active-low reset
- fpgaAddr  in  32  front-end write address
- fpgaWData  in  32  front-end write data
- fpgaWrEn  in  1  front-end write enable (level; write every cycle high)
- fpgaStart  in  1  front-end CPU-enable request; rising edge launches a run
- fpgaRdAddr  in  32  front-end read address
- fpgaRdData  out  32  front-end read data, registered
- cpuAddr  in  32  CPU data address
- cpuWData  in  32  CPU store data
- cpuWrEn  in  1  CPU store strobe
- cpuRdData  out  32  CPU load data, combinational
- cpuRun  out  1  CPU execute enable
- busy  out  1  high in RUN

## Operation
- Storage: regA, regB, regOp[3:0], regRes (all 32-bit except regOp); start-edge flop startQ; watchdog cnt (8-bit min, sized for TIMEOUT).
- Status word: {29'b0, err, done, run}. Each bit is 1 in the matching state.
- States: IDLE, RUN, DONE, ERR.
- IDLE: fpgaWrEn to A_ADDR/B_ADDR loads regA/regB. fpgaWrEn to OP_ADDR loads regOp with fpgaWData[3:0]. Other addresses are ignored. Rising edge of fpgaStart (fpgaStart & ~startQ) → RUN with cnt=0.
- RUN: cpuRun=1, busy=1. All front-end writes are ignored; operands stay frozen. cnt increments each cycle.
  - cpuWrEn to RES_ADDR → regRes=cpuWData, go to DONE.
  - Otherwise, cnt==TIMEOUT-1 → regRes=32'hFFFF_FFFF, go to ERR.
  - Result write and timeout in the same cycle → DONE wins (CPU data stored).
- DONE/ERR: cpuRun=0. CPU writes are ignored. A front-end write to A_ADDR loads regA and returns to IDLE; regRes is retained. Front-end writes to B/OP in these states are ignored. A new start edge is ignored until IDLE.
- CPU writes outside RUN, or to any address other than RES_ADDR, are ignored.
- CPU read map (combinational):
  - A_ADDR → regA
  - B_ADDR → regB
  - OP_ADDR → {28'b0, regOp}
  - RES_ADDR → regRes
  - STAT_ADDR → status
  - anything else → 0
- Front-end read map (registered): A_ADDR, B_ADDR, OP_ADDR, RES_ADDR as above; anything else → 0.
- Simultaneous front-end write and start edge in IDLE: the write is accepted, then RUN begins the next cycle with the new value.

## Timing
- Reset (asynchronous, any state including mid-RUN): state=IDLE; regA, regB, regOp, regRes, cnt, startQ all 0. Outputs: fpgaRdData=0, cpuRun=0, busy=0, cpuRdData=0 (address-dependent on 0 registers).
- Start edge sampled at clock k → state=RUN and cpuRun=1 after edge k. The CPU's first enabled cycle is k+1.
- Result store at edge m in RUN → DONE after edge m. cpuRun low from m+... onward (registered state). regRes is visible on fpgaRdData after edge m+1 (one-cycle read latency).
- Timeout: with no result, ERR is entered at the edge where cnt==TIMEOUT-1. That gives exactly TIMEOUT RUN cycles.
- Register writes take effect at the sampling edge; cpuRdData reflects them in the following cycle.
- fpgaStart held high does not retrigger; only 0→1 transitions count.

## Test plan
- Load: write A=12, OP=8, B=34 in IDLE, pulse fpgaStart. Expect cpuRun=1 the next cycle. CPU reads 220→12, 300→8, 260→34, 464→1.
- Result: in RUN, CPU stores 46 to 460. Expect DONE, cpuRun=0, status=2. fpgaRdAddr=460 returns 46 one cycle later.
- Timeout: start with TIMEOUT=200 and no CPU store. Expect cpuRun high for exactly 200 cycles, then ERR, status=4, result=FFFF_FFFF.
- Collision: CPU store 99 to 460 on the cycle cnt==199. Expect DONE, result=99, err=0.
- Freeze/return: in RUN, front-end writes A=7; regA is unchanged. After DONE, write A=7 → IDLE, regA=7, regRes retained.
- Reset mid-RUN: assert reset at cnt=50. Expect immediate IDLE, cpuRun=0, all registers 0. Holding fpgaStart high through reset release gives no run until it drops and rises again.
